alu_arbiter: RTL and testbench

- Shares the single 8-bit ALU (combinational 8-bit adder, 2-bit flags {OF,0}) between two requesters, e.g. the execute stage (port 0) and the address/PC-increment path (port 1).
- Arbitrates, registers the winner's operands onto the ALU inputs for one cycle, then captures the ALU result and flags into a response register.
- Sits between the requesters and the ALU; it is the only block that drives the ALU operand and op inputs.

---
 rtl/alu_arbiter.sv | 124 ++++++++++++
 tb/tb_alu_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-port arbiter in front of the shared 8-bit ALU.
// Issue one cycle, capture next; round-robin or fixed priority.
module alu_arbiter #(
  parameter bit FIXED_PRIORITY = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic [7:0] a0,
  input  logic [7:0] b0,
  input  logic       req1,
  input  logic [7:0] a1,
  input  logic [7:0] b1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       rsp_valid0,
  output logic       rsp_valid1,
  output logic [7:0] rsp_result,
  output logic [1:0] rsp_flags,
  output logic [7:0] alu_operand1,
  output logic [7:0] alu_operand2,
  output logic       alu_sigALUOp,
  input  logic [7:0] alu_result,
  input  logic [1:0] alu_flags
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_e;

  state_e     state_q;
  logic       win_q;
  logic       last_q;
  logic [7:0] op1_q;
  logic [7:0] op2_q;
  logic [7:0] res_q;
  logic [1:0] flg_q;
  logic       gnt0_q;
  logic       gnt1_q;
  logic       rv0_q;
  logic       rv1_q;

  logic       any_req;
  logic       pick;
  logic [7:0] a_sel;
  logic [7:0] b_sel;

  assign any_req = req0 | req1;

  always_comb begin
    pick = 1'b0;
    unique case (1'b1)
      (req0 & req1):
        pick = FIXED_PRIORITY ? 1'b0 : ~last_q;
      (req1 & ~req0):
        pick = 1'b1;
      default:
        pick = 1'b0;
    endcase
  end

  assign a_sel = pick ? a1 : a0;
  assign b_sel = pick ? b1 : b0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      win_q   <= 1'b0;
      last_q  <= 1'b1;
      op1_q   <= 8'h00;
      op2_q   <= 8'h00;
      res_q   <= 8'h00;
      flg_q   <= 2'b00;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
    end else begin
      gnt0_q <= 1'b0;
      gnt1_q <= 1'b0;
      rv0_q  <= 1'b0;
      rv1_q  <= 1'b0;
      case (state_q)
        IDLE, RESP: begin
          // RESP re-arbitrates so a held req issues back-to-back
          if (any_req) begin
            state_q <= ISSUE;
            win_q   <= pick;
            op1_q   <= a_sel;
            op2_q   <= b_sel;
            gnt0_q  <= ~pick;
            gnt1_q  <= pick;
          end else begin
            state_q <= IDLE;
          end
        end
        ISSUE: begin
          state_q <= RESP;
          res_q   <= alu_result;
          flg_q   <= alu_flags;
          last_q  <= win_q;
          rv0_q   <= ~win_q;
          rv1_q   <= win_q;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign gnt0         = gnt0_q;
  assign gnt1         = gnt1_q;
  assign rsp_valid0   = rv0_q;
  assign rsp_valid1   = rv1_q;
  assign rsp_result   = res_q;
  assign rsp_flags    = flg_q;
  assign alu_operand1 = op1_q;
  assign alu_operand2 = op2_q;
  assign alu_sigALUOp = 1'b0;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: round-robin instance A, fixed-priority B.
// External ALU modelled here; responses checked via scoreboards.
module tb_alu_arbiter;

  typedef struct {
    bit         port;
    logic [7:0] res;
    logic [1:0] flg;
  } exp_t;

  typedef struct {
    bit         port;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic [1:0] flg;
  } vec_t;

  logic clk;
  logic reset;

  logic       req0_a, req1_a, req0_b, req1_b;
  logic [7:0] a0_a, b0_a, a1_a, b1_a;
  logic [7:0] a0_b, b0_b, a1_b, b1_b;
  logic       gnt0_a, gnt1_a, rv0_a, rv1_a, op_a;
  logic       gnt0_b, gnt1_b, rv0_b, rv1_b, op_b;
  logic [7:0] res_a, o1_a, o2_a, ar_a;
  logic [7:0] res_b, o1_b, o2_b, ar_b;
  logic [1:0] flg_a, af_a, flg_b, af_b;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  vec_t vecs[8];

  function automatic logic [1:0] alu_flg(logic [7:0] x, logic [7:0] y);
    logic [7:0] s;
    s = x + y;
    return {(x[7] == y[7]) && (s[7] != x[7]), 1'b0};
  endfunction

  assign ar_a = o1_a + o2_a;
  assign af_a = alu_flg(o1_a, o2_a);
  assign ar_b = o1_b + o2_b;
  assign af_b = alu_flg(o1_b, o2_b);

  alu_arbiter #(.FIXED_PRIORITY(1'b0)) u_a (
    .clk(clk), .reset(reset),
    .req0(req0_a), .a0(a0_a), .b0(b0_a),
    .req1(req1_a), .a1(a1_a), .b1(b1_a),
    .gnt0(gnt0_a), .gnt1(gnt1_a),
    .rsp_valid0(rv0_a), .rsp_valid1(rv1_a),
    .rsp_result(res_a), .rsp_flags(flg_a),
    .alu_operand1(o1_a), .alu_operand2(o2_a),
    .alu_sigALUOp(op_a),
    .alu_result(ar_a), .alu_flags(af_a)
  );

  alu_arbiter #(.FIXED_PRIORITY(1'b1)) u_b (
    .clk(clk), .reset(reset),
    .req0(req0_b), .a0(a0_b), .b0(b0_b),
    .req1(req1_b), .a1(a1_b), .b1(b1_b),
    .gnt0(gnt0_b), .gnt1(gnt1_b),
    .rsp_valid0(rv0_b), .rsp_valid1(rv1_b),
    .rsp_result(res_b), .rsp_flags(flg_b),
    .alu_operand1(o1_b), .alu_operand2(o2_b),
    .alu_sigALUOp(op_b),
    .alu_result(ar_b), .alu_flags(af_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && (rv0_a || rv1_a)) begin
      chk("A rsp excl", int'(rv0_a & rv1_a), 0);
      if (q_a.size() == 0) begin
        chk("A unexpected rsp", 1, 0);
      end else begin
        exp_t e;
        e = q_a.pop_front();
        chk("A rsp port", int'(rv1_a), int'(e.port));
        chk("A rsp result", int'(res_a), int'(e.res));
        chk("A rsp flags", int'(flg_a), int'(e.flg));
      end
    end
    if (!reset && (gnt0_a || gnt1_a))
      chk("A gnt excl", int'(gnt0_a & gnt1_a), 0);
  end

  always @(negedge clk) begin
    if (!reset && (rv0_b || rv1_b)) begin
      chk("B rsp excl", int'(rv0_b & rv1_b), 0);
      if (q_b.size() == 0) begin
        chk("B unexpected rsp", 1, 0);
      end else begin
        exp_t e;
        e = q_b.pop_front();
        chk("B rsp port", int'(rv1_b), int'(e.port));
        chk("B rsp result", int'(res_b), int'(e.res));
        chk("B rsp flags", int'(flg_b), int'(e.flg));
      end
    end
    if (!reset && (gnt0_b || gnt1_b))
      chk("B gnt excl", int'(gnt0_b & gnt1_b), 0);
  end

  task automatic do_op_a(vec_t v, string nm);
    @(negedge clk);
    if (v.port) begin
      req1_a = 1'b1; a1_a = v.a; b1_a = v.b;
    end else begin
      req0_a = 1'b1; a0_a = v.a; b0_a = v.b;
    end
    q_a.push_back('{v.port, v.res, v.flg});
    @(negedge clk);
    chk({nm, " gnt0"}, int'(gnt0_a), int'(!v.port));
    chk({nm, " gnt1"}, int'(gnt1_a), int'(v.port));
    chk({nm, " op1"}, int'(o1_a), int'(v.a));
    chk({nm, " op2"}, int'(o2_a), int'(v.b));
    req0_a = 1'b0;
    req1_a = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk({nm, " hold"}, int'(res_a), int'(v.res));
  endtask

  initial begin
    reset = 1'b1;
    req0_a = 0; req1_a = 0; req0_b = 0; req1_b = 0;
    a0_a = 0; b0_a = 0; a1_a = 0; b1_a = 0;
    a0_b = 0; b0_b = 0; a1_b = 0; b1_b = 0;

    vecs[0] = '{1'b0, 8'h12, 8'h34, 8'h46, 2'b00};
    vecs[1] = '{1'b1, 8'h7F, 8'h01, 8'h80, 2'b10};
    vecs[2] = '{1'b0, 8'hFF, 8'h01, 8'h00, 2'b00};
    vecs[3] = '{1'b1, 8'h80, 8'h80, 8'h00, 2'b10};
    vecs[4] = '{1'b0, 8'hC0, 8'hC0, 8'h80, 2'b00};
    vecs[5] = '{1'b1, 8'h55, 8'h2A, 8'h7F, 2'b00};
    vecs[6] = '{1'b0, 8'h7F, 8'h7F, 8'hFE, 2'b10};
    vecs[7] = '{1'b1, 8'h00, 8'h00, 8'h00, 2'b00};

    #7;
    chk("rst gnt", int'({gnt0_a, gnt1_a, gnt0_b, gnt1_b}), 0);
    chk("rst rv", int'({rv0_a, rv1_a, rv0_b, rv1_b}), 0);
    chk("rst res", int'(res_a | res_b), 0);
    chk("rst flg", int'(flg_a | flg_b), 0);
    chk("rst ops", int'(o1_a | o2_a | o1_b | o2_b), 0);
    chk("rst aluop", int'(op_a | op_b), 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 8; i++)
      do_op_a(vecs[i], $sformatf("vec%0d", i));

    // both held: last grant was port 1, so port 0 first
    @(negedge clk);
    req0_a = 1; a0_a = 8'h10; b0_a = 8'h20;
    req1_a = 1; a1_a = 8'h40; b1_a = 8'h05;
    q_a.push_back('{1'b0, 8'h30, 2'b00});
    q_a.push_back('{1'b1, 8'h45, 2'b00});
    q_a.push_back('{1'b0, 8'h30, 2'b00});
    q_a.push_back('{1'b1, 8'h45, 2'b00});
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      chk($sformatf("rr c%0d gnt0", c), int'(gnt0_a), int'(c == 1 || c == 5));
      chk($sformatf("rr c%0d gnt1", c), int'(gnt1_a), int'(c == 3 || c == 7));
      if (c == 7) begin
        req0_a = 0; req1_a = 0;
      end
    end
    @(negedge clk);

    @(negedge clk);
    req0_a = 1; a0_a = 8'h01; b0_a = 8'h02;
    q_a.push_back('{1'b0, 8'h03, 2'b00});
    @(negedge clk);
    chk("b2b gnt first", int'(gnt0_a), 1);
    a0_a = 8'h03; b0_a = 8'h04;
    q_a.push_back('{1'b0, 8'h07, 2'b00});
    @(negedge clk);
    chk("b2b gnt in resp", int'(gnt0_a), 0);
    @(negedge clk);
    chk("b2b gnt second", int'(gnt0_a), 1);
    chk("b2b op1", int'(o1_a), 8'h03);
    req0_a = 0;
    @(negedge clk);
    @(negedge clk);

    @(negedge clk);
    req0_b = 1; a0_b = 8'h11; b0_b = 8'h22;
    req1_b = 1; a1_b = 8'hF0; b1_b = 8'h20;
    q_b.push_back('{1'b0, 8'h33, 2'b00});
    q_b.push_back('{1'b0, 8'h33, 2'b00});
    q_b.push_back('{1'b0, 8'h33, 2'b00});
    q_b.push_back('{1'b1, 8'h10, 2'b00});
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      chk($sformatf("fp c%0d gnt0", c), int'(gnt0_b), int'(c == 1 || c == 3 || c == 5));
      chk($sformatf("fp c%0d gnt1", c), int'(gnt1_b), int'(c == 7));
      if (c == 5) req0_b = 0;
      if (c == 7) req1_b = 0;
    end
    @(negedge clk);

    @(negedge clk);
    req0_a = 1; a0_a = 8'h5A; b0_a = 8'h11;
    @(negedge clk);
    chk("rst-mid gnt before", int'(gnt0_a), 1);
    #1;
    reset = 1'b1;
    #1;
    chk("rst-mid gnt", int'(gnt0_a | gnt1_a), 0);
    chk("rst-mid rv", int'(rv0_a | rv1_a), 0);
    chk("rst-mid res", int'(res_a), 0);
    chk("rst-mid flg", int'(flg_a), 0);
    chk("rst-mid op1", int'(o1_a), 0);
    chk("rst-mid op2", int'(o2_a), 0);
    req0_a = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    do_op_a('{1'b0, 8'h21, 8'h21, 8'h42, 2'b00}, "post-rst");

    repeat (2) @(negedge clk);
    chk("A queue drained", q_a.size(), 0);
    chk("B queue drained", q_b.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
